// File: rtl/sifh_frame_sequencer.sv
// Frame-level controller for the serial SiFH pipeline: per frame it runs
// clear -> accumulate -> peak-detect twice, first coarse (pass 0) then fine (pass 1).
module sifh_frame_sequencer #(
    parameter int unsigned NP        = 12,
    parameter int unsigned NB        = 6,
    parameter int unsigned PIXEL_NUM = 4,
    parameter int unsigned DATA_NUM  = 2,
    parameter int unsigned ACQ_NUM   = 3,
    localparam int unsigned PW       = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
    localparam int unsigned BIN_NUM  = PIXEL_NUM << NB,
    localparam int unsigned CAW      = $clog2(BIN_NUM)
) (
    input  logic           clk,
    input  logic           res,
    input  logic           start,
    input  logic           in_valid,
    input  logic [NP-1:0]  in_data,
    output logic           in_ready,
    output logic           clr_en,
    output logic [CAW-1:0] clr_addr,
    output logic           hb_wr_en,
    output logic [NP-1:0]  hb_data,
    output logic [PW-1:0]  hb_pixel,
    output logic           hb_pass,
    output logic           pk_start,
    input  logic           pk_done,
    output logic           frame_done,
    output logic           busy
);

    localparam int unsigned DW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int unsigned AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR0 = 3'd1,
        ACC0 = 3'd2,
        PK0  = 3'd3,
        CLR1 = 3'd4,
        ACC1 = 3'd5,
        PK1  = 3'd6,
        DONE = 3'd7
    } state_t;

    state_t          state;
    logic [DW-1:0]   data_cnt;
    logic [PW-1:0]   pixel_cnt;
    logic [AW-1:0]   acq_cnt;

    logic            accept;
    logic            data_last;
    logic            pixel_last;
    logic            acq_last;
    logic            clr_last;

    // Sample acceptance is a pure decode of the accumulate states.
    assign in_ready   = (state == ACC0) || (state == ACC1);
    assign accept     = in_valid & in_ready;

    assign data_last  = (data_cnt  == DW'(DATA_NUM - 1));
    assign pixel_last = (pixel_cnt == PW'(PIXEL_NUM - 1));
    assign acq_last   = (acq_cnt   == AW'(ACQ_NUM - 1));
    assign clr_last   = (clr_addr  == CAW'(BIN_NUM - 1));

    // Sequencer state, sample counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            data_cnt   <= '0;
            pixel_cnt  <= '0;
            acq_cnt    <= '0;
            clr_en     <= 1'b0;
            clr_addr   <= '0;
            hb_wr_en   <= 1'b0;
            hb_data    <= '0;
            hb_pixel   <= '0;
            hb_pass    <= 1'b0;
            pk_start   <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            hb_wr_en   <= 1'b0;
            pk_start   <= 1'b0;
            frame_done <= 1'b0;

            // Tag and forward the accepted sample with one cycle of latency.
            if (accept) begin
                hb_wr_en <= 1'b1;
                hb_data  <= in_data;
                hb_pixel <= pixel_cnt;
                hb_pass  <= (state == ACC1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLR0;
                        clr_en   <= 1'b1;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end
                end

                CLR0, CLR1: begin
                    if (clr_last) begin
                        clr_en   <= 1'b0;
                        clr_addr <= '0;
                        state    <= (state == CLR0) ? ACC0 : ACC1;
                    end else begin
                        clr_addr <= clr_addr + CAW'(1);
                    end
                end

                ACC0, ACC1: begin
                    if (accept) begin
                        if (data_last) begin
                            data_cnt <= '0;
                            if (pixel_last) begin
                                pixel_cnt <= '0;
                                if (acq_last) begin
                                    acq_cnt  <= '0;
                                    pk_start <= 1'b1;
                                    state    <= (state == ACC0) ? PK0 : PK1;
                                end else begin
                                    acq_cnt <= acq_cnt + AW'(1);
                                end
                            end else begin
                                pixel_cnt <= pixel_cnt + PW'(1);
                            end
                        end else begin
                            data_cnt <= data_cnt + DW'(1);
                        end
                    end
                end

                // pk_done may arrive together with pk_start.
                PK0: begin
                    if (pk_done) begin
                        state    <= CLR1;
                        clr_en   <= 1'b1;
                        clr_addr <= '0;
                    end
                end

                PK1: begin
                    if (pk_done) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
